// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier that borrows the shared ALU.
// It uses ALU OR for the zero test and ALU ADD for accumulation; the product is the low WIDTH bits.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_gin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_zout
);

    // state | meaning
    // IDLE  | waiting for start, operands captured on acceptance
    // CHECK | ALU OR tests the remaining multiplier for zero (early exit)
    // ADD   | ALU ADD accumulates the multiplicand if mplier[0], then shift
    // DONE  | product registered, one-cycle done pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0]       GIN_OR   = 3'b001;
    localparam logic [2:0]       GIN_ADD  = 3'b010;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        alu_gin   = GIN_ADD;
        alu_a     = '0;
        alu_b     = '0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                alu_gin = GIN_OR;
                alu_a   = mplier_q;
                state_d = alu_zout ? DONE : ADD;
            end
            ADD: begin
                alu_a = acc_q;
                alu_b = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = alu_sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == CNT_LAST) ? DONE : CHECK;
            end
            DONE: begin
                product_d = acc_q;
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU beside the DUT, with product and latency
// computed arithmetically from the operands.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] product, alu_a, alu_b, alu_sum;
    logic [2:0]  alu_gin;
    logic        alu_zout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared ALU model
    assign alu_sum  = (alu_gin == 3'b001) ? (alu_a | alu_b) :
                      (alu_gin == 3'b010) ? (alu_a + alu_b) : 32'hDEAD_BEEF;
    assign alu_zout = ~|alu_sum;

    alu_mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
        .alu_sum(alu_sum), .alu_zout(alu_zout)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    // One CHECK+ADD pair per multiplier bit up to the top set bit, a final CHECK to see zero,
    // then DONE; bit 31 exits on the counter without the final CHECK.
    function automatic int ref_latency(input logic [31:0] b);
        int k;
        if (b == 0) return 2;
        k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i;
        if (k == 31) return 65;
        return 2 * k + 4;
    endfunction

    // Cycle 1 is the state after the edge that accepts start.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        int lat;
        bit legal;
        lat = 0;
        op_a = a;
        op_b = b;
        start = 1'b1;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            else begin
                op_a = $urandom;
                op_b = $urandom;
            end
            legal = (alu_gin == 3'b001) || (alu_gin == 3'b010);
            if (!legal) check({name, " gin"}, {29'd0, alu_gin}, 32'd2);
            if (busy !== 1'b1) check({name, " busy"}, {31'd0, busy}, 32'd1);
            if (done === 1'b1) lat = c;
        end
        check({name, " done_cycle"}, lat, ref_latency(b));
        @(negedge clk);
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
        check({name, " idle_after"}, {31'd0, busy}, 32'd0);
        check({name, " product"}, product, ref_product(a, b));
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          any_done;
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst product", product, 32'd0);
        check("rst gin", {29'd0, alu_gin}, 32'd2);
        check("rst alu_a", alu_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", {31'd0, busy}, 32'd0);

        run_op("6x7", 32'd6, 32'd7, 1'b0);
        run_op("b_zero", 32'h1234, 32'd0, 1'b0);
        run_op("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("ovf16", 32'h1_0000, 32'h1_0000, 1'b0);

        // start held high throughout; operands scrambled after capture
        run_op("hold1", 32'd123, 32'd45, 1'b1);
        run_op("hold2", 32'hABCD, 32'h0000_0F01, 1'b1);
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rb = rb >> $urandom_range(0, 31);
            if (i == 3) rb = 32'd1;
            run_op("rand", ra, rb, 1'b0);
        end

        // reset mid-operation aborts without done
        op_a = 32'd3;
        op_b = 32'h8000_0000;
        start = 1'b1;
        any_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) any_done++;
        end
        check("abort busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort product", product, 32'd0);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done === 1'b1) any_done++;
        end
        check("abort no_done", any_done, 32'd0);
        check("abort still_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
